conv_out_requant: RTL and testbench

// - Downstream stage of the convolver. Consumes the raw 36-bit MAC stream (output_mac) on every
//   mac_enable cycle and discards the wrap-around columns produced by the line buffer.
// - Adds a per-filter bias, rounds and requantizes each result to WID_PE_BITS signed, applies

---
 rtl/conv_out_requant_pkg.sv | 56 +++++
 rtl/pe_out_fifo.sv | 67 ++++++
 rtl/conv_out_requant.sv | 178 +++++++++++++++++
 tb/tb_conv_out_requant.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_out_requant_pkg.sv
// rtl/conv_out_requant_pkg.sv - shared widths, FSM encoding and requant helper
//
// Purpose: constants and types shared by conv_out_requant and pe_out_fifo.
// Contents:
//   WID_ACC / WID_OUT / FRAC_BITS / FIFO_DEPTH / K  - datapath and frame geometry
//   state_t                                         - control FSM encoding
//   rq_t, requant()                                 - shift, ReLU and saturation
package conv_out_requant_pkg;

  localparam int WID_ACC     = 36;
  localparam int WID_OUT     = 16;
  localparam int FRAC_BITS   = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int K           = 3;
  localparam int WID_EXT     = WID_ACC + 2;
  localparam int AFULL_LEVEL = FIFO_DEPTH - 4;

  localparam logic signed [WID_EXT-1:0] ROUND_HALF = WID_EXT'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [WID_EXT-1:0] OUT_MAX    = WID_EXT'((1 << (WID_OUT - 1)) - 1);
  localparam logic signed [WID_EXT-1:0] OUT_MIN    = ~OUT_MAX;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic               sat;
    logic [WID_OUT-1:0] data;
  } rq_t;

  // Second pipeline stage: drop fraction bits of the rounded sum, optional
  // ReLU, then clamp into the signed output range. ReLU is applied first so a
  // large negative input under ReLU yields 0 without flagging saturation.
  function automatic rq_t requant(input logic signed [WID_EXT-1:0] sum,
                                  input logic                      relu);
    logic signed [WID_EXT-1:0] q;
    rq_t r;
    q = sum >>> FRAC_BITS;
    if (relu && q[WID_EXT-1]) q = '0;
    if (q > OUT_MAX) begin
      r.sat  = 1'b1;
      r.data = OUT_MAX[WID_OUT-1:0];
    end else if (q < OUT_MIN) begin
      r.sat  = 1'b1;
      r.data = OUT_MIN[WID_OUT-1:0];
    end else begin
      r.sat  = 1'b0;
      r.data = q[WID_OUT-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_out_fifo.sv
// rtl/pe_out_fifo.sv - synchronous first-word-fall-through output FIFO
//
// Purpose: holds requantized pixels (plus side bits) until the consumer takes them.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push, push_data write request and word; accepted if not full or popping
//   pop             consumer accepts head word (ignored when empty)
//   pop_data        head word, 0 while empty
//   count           occupancy 0..DEPTH
//   full, empty     occupancy flags
//   afull           count >= AFULL
module pe_out_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16,
  parameter int AFULL = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic               full,
  output logic               empty,
  output logic               afull
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign afull = (count >= (AW+1)'(AFULL));

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_out_requant.sv
// rtl/conv_out_requant.sv - convolver output stage: crop, bias, requantize, queue
//
// Purpose: takes the raw MAC stream, drops line-buffer wrap columns, adds bias,
// rounds/requantizes to WID_OUT signed with optional ReLU and queues results.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   start                       pulse in IDLE: latch config, begin frame
//   img_width, img_height       input image W, H
//   bias, relu_en               per-filter bias (pixel Q format), ReLU enable
//   in_valid, in_mac            MAC stream beat
//   out_data, out_valid,
//   out_ready, out_last         FWFT output handshake, last pixel of frame
//   fifo_afull                  FIFO occupancy >= FIFO_DEPTH-4
//   busy, done                  not idle / 1-cycle frame-complete pulse
//   sat_flag, drop_flag         sticky saturation / FIFO-overflow flags
module conv_out_requant
  import conv_out_requant_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         img_width,
  input  logic [7:0]         img_height,
  input  logic [WID_OUT-1:0] bias,
  input  logic               relu_en,
  input  logic               in_valid,
  input  logic [WID_ACC-1:0] in_mac,
  output logic [WID_OUT-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               fifo_afull,
  output logic               busy,
  output logic               done,
  output logic               sat_flag,
  output logic               drop_flag
);

  state_t             state;
  logic [7:0]         width_r;
  logic [7:0]         height_r;
  logic [WID_OUT-1:0] bias_r;
  logic               relu_r;
  logic [7:0]         col;
  logic [7:0]         row;
  logic [7:0]         last_col;
  logic [7:0]         last_row;
  logic               beat;
  logic               kept;
  logic               frame_end;

  logic signed [WID_EXT-1:0] mac_ext;
  logic signed [WID_EXT-1:0] bias_ext;
  logic signed [WID_EXT-1:0] sum;
  rq_t                       rq;

  logic                      s1_v;
  logic                      s1_last;
  logic signed [WID_EXT-1:0] s1_sum;
  logic                      s2_v;
  logic                      s2_last;
  logic [WID_OUT-1:0]        s2_data;

  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        fifo_full;
  logic                        fifo_empty;

  assign last_col  = width_r - 8'(K);
  assign last_row  = height_r - 8'(K);
  assign beat      = (state == S_RUN) && in_valid;
  assign kept      = beat && (col <= last_col);
  assign frame_end = kept && (row == last_row) && (col == last_col);

  // Full-precision stage 1: bias is moved into accumulator scale and half an
  // output LSB added so the later arithmetic shift rounds to nearest.
  assign mac_ext  = WID_EXT'(signed'(in_mac));
  assign bias_ext = WID_EXT'(signed'(bias_r));
  assign sum      = mac_ext + (bias_ext <<< FRAC_BITS) + ROUND_HALF;
  assign rq       = requant(s1_sum, relu_r);

  assign busy      = (state != S_IDLE);
  assign out_valid = !fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      width_r   <= '0;
      height_r  <= '0;
      bias_r    <= '0;
      relu_r    <= 1'b0;
      col       <= '0;
      row       <= '0;
      done      <= 1'b0;
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
      s1_v      <= 1'b0;
      s1_last   <= 1'b0;
      s1_sum    <= '0;
      s2_v      <= 1'b0;
      s2_last   <= 1'b0;
      s2_data   <= '0;
    end else begin
      done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            width_r   <= img_width;
            height_r  <= img_height;
            bias_r    <= bias;
            relu_r    <= relu_en;
            col       <= '0;
            row       <= '0;
            sat_flag  <= 1'b0;
            drop_flag <= 1'b0;
            // Image smaller than the kernel has no valid window at all.
            if (img_width < 8'(K) || img_height < 8'(K)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (beat) begin
            if (col == width_r - 8'd1) begin
              col <= '0;
              row <= row + 8'd1;
            end else begin
              col <= col + 8'd1;
            end
          end
          if (frame_end) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!s1_v && !s2_v && fifo_count == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      s1_v    <= kept;
      s1_last <= frame_end;
      if (kept) s1_sum <= sum;

      s2_v    <= s1_v;
      s2_last <= s1_last;
      if (s1_v) begin
        s2_data <= rq.data;
        if (rq.sat) sat_flag <= 1'b1;
      end

      // Upstream never stalls: a result arriving at a full FIFO with no pop is lost.
      if (s2_v && fifo_full && !out_ready) drop_flag <= 1'b1;
    end
  end

  pe_out_fifo #(
    .WIDTH (WID_OUT + 1),
    .DEPTH (FIFO_DEPTH),
    .AFULL (AFULL_LEVEL)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s2_v),
    .push_data ({s2_last, s2_data}),
    .pop       (out_ready),
    .pop_data  ({out_last, out_data}),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .afull     (fifo_afull)
  );

endmodule

// File: tb/tb_conv_out_requant.sv
// tb/tb_conv_out_requant.sv - self-checking bench for conv_out_requant
module tb_conv_out_requant;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  img_width;
  logic [7:0]  img_height;
  logic [15:0] bias;
  logic        relu_en;
  logic        in_valid;
  logic [35:0] in_mac;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        fifo_afull;
  logic        busy;
  logic        done;
  logic        sat_flag;
  logic        drop_flag;

  int total = 0;
  int bad   = 0;

  logic [16:0] exp_q[$];
  bit          exp_sat;
  bit          exp_drop;

  conv_out_requant dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .img_width  (img_width),
    .img_height (img_height),
    .bias       (bias),
    .relu_en    (relu_en),
    .in_valid   (in_valid),
    .in_mac     (in_mac),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .fifo_afull (fifo_afull),
    .busy       (busy),
    .done       (done),
    .sat_flag   (sat_flag),
    .drop_flag  (drop_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every accepted output word is compared with the oldest expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      logic [16:0] e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: got last=%b data=%h, required no output", out_last, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_last, out_data} !== e) begin
          bad++;
          $display("FAIL out_word: got last=%b data=%h, required last=%b data=%h",
                   out_last, out_data, e[16], e[15:0]);
        end
      end
    end
  end

  function automatic logic [16:0] model(input longint mac, input logic [15:0] b, input bit relu);
    longint s;
    s = mac + longint'($signed(b)) * 256 + 128;
    s = s >>> 8;
    if (relu && s < 0) s = 0;
    if (s > 32767)       return {1'b1, 16'h7FFF};
    else if (s < -32768) return {1'b1, 16'h8000};
    else                 return {1'b0, 16'(s)};
  endfunction

  task automatic do_start(input int w, input int h, input logic [15:0] b, input bit relu);
    @(posedge clk); #1;
    start = 1'b1; img_width = 8'(w); img_height = 8'(h); bias = b; relu_en = relu;
    exp_sat = 0; exp_drop = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        got = 1;
        break;
      end
    end
  endtask

  // mode 0: mac=k<<8, 1: constant cmac, 2: random. Pushes expectations for
  // kept beats up to max_push; returns early once abort_kept pixels were kept.
  task automatic run_frame(input int w, input int h, input logic [15:0] b, input bit relu,
                           input int mode, input longint cmac, input int max_push,
                           input int abort_kept, input int restart_beat);
    int kept_n, pushed, col, row;
    longint mac;
    logic signed [25:0] rnd26;
    logic [16:0] r;
    do_start(w, h, b, relu);
    kept_n = 0; pushed = 0;
    for (int k = 0; k < w * (h - 2); k++) begin
      rnd26 = 26'($urandom);
      case (mode)
        0:       mac = longint'(k) * 256;
        1:       mac = cmac;
        default: mac = longint'(rnd26);
      endcase
      in_valid = 1'b1;
      in_mac   = 36'(mac);
      if (k == restart_beat) begin
        start = 1'b1; img_width = 8'd3; img_height = 8'd3; bias = 16'h7000; relu_en = ~relu;
      end
      col = k % w; row = k / w;
      if (col <= w - 3) begin
        r = model(mac, b, relu);
        if (r[16]) exp_sat = 1;
        if (pushed < max_push) begin
          exp_q.push_back({(row == h - 3 && col == w - 3), r[15:0]});
          pushed++;
        end else begin
          exp_drop = 1;
        end
        kept_n++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (kept_n == abort_kept) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; img_width = 0; img_height = 0; bias = 0; relu_en = 0;
    in_valid = 1'b0; in_mac = 0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({out_valid, busy, done, sat_flag, drop_flag, fifo_afull, out_last} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got v/b/d/s/dr/af/l=%b, required 0000000",
               {out_valid, busy, done, sat_flag, drop_flag, fifo_afull, out_last});
    end
    total++;
    if (out_data !== 16'h0) begin
      bad++; $display("FAIL reset_data: got %h, required 0000", out_data);
    end
  endtask

  task automatic test_basic;
    bit got;
    // bench's own constants: pixels 0,1,2,5,6,7,10,11,12 with last on 12
    int vals[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    for (int i = 0; i < 9; i++) exp_q.push_back({(i == 8), 16'(vals[i])});
    run_frame(5, 5, 16'h0, 0, 0, 0, 0, -1, -1);
    wait_done(100, got);
    total++;
    if (got !== 1'b1) begin bad++; $display("FAIL basic_done: got no done, required done"); end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL basic_count: got %0d pending, required 0", exp_q.size());
    end
    total++;
    if (sat_flag !== 1'b0 || drop_flag !== 1'b0) begin
      bad++; $display("FAIL basic_flags: got sat=%b drop=%b, required 0 0", sat_flag, drop_flag);
    end
  endtask

  task automatic test_latency;
    bit got;
    logic exp_v[3] = '{1'b0, 1'b0, 1'b1};
    do_start(3, 3, 16'h0, 0);
    in_valid = 1'b1; in_mac = 36'h300;
    exp_q.push_back({1'b1, 16'h0003});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++;
      if (out_valid !== exp_v[i]) begin
        bad++; $display("FAIL latency_%0d: got out_valid=%b, required %b", i, out_valid, exp_v[i]);
      end
    end
    wait_done(50, got);
    total++;
    if (got !== 1'b1) begin bad++; $display("FAIL latency_done: got no done, required done"); end
  endtask

  task automatic test_arith;
    bit got;
    longint      macs[5] = '{128, -129, 2147483392, -1280, -2147483392};
    logic [15:0] bs[5]   = '{16'h0001, 16'h0, 16'h0, 16'h0, 16'h0};
    bit          rl[5]   = '{0, 0, 0, 1, 0};
    logic [15:0] ed[5]   = '{16'h0002, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h8000};
    bit          es[5]   = '{0, 0, 1, 0, 1};
    for (int i = 0; i < 5; i++) begin
      do_start(3, 3, bs[i], rl[i]);
      in_valid = 1'b1; in_mac = 36'(macs[i]);
      exp_q.push_back({1'b1, ed[i]});
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_done(50, got);
      total++;
      if (got !== 1'b1 || exp_q.size() != 0) begin
        bad++; $display("FAIL arith_%0d_done: got done=%b pending=%0d, required 1 0", i, got, exp_q.size());
      end
      total++;
      if (sat_flag !== es[i]) begin
        bad++; $display("FAIL arith_%0d_sat: got %b, required %b", i, sat_flag, es[i]);
      end
    end
  endtask

  task automatic test_control;
    bit got;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_mac = 36'(i * 256 + 77);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL idle_beats: got valid=%b busy=%b, required 0 0", out_valid, busy);
      end
    end
    run_frame(4, 4, 16'h0, 0, 0, 0, 1000, -1, 2);
    wait_done(100, got);
    total++;
    if (got !== 1'b1 || exp_q.size() != 0) begin
      bad++; $display("FAIL restart_ignored: got done=%b pending=%0d, required 1 0", got, exp_q.size());
    end
  endtask

  task automatic test_degenerate;
    int ws[2] = '{2, 5};
    int hs[2] = '{5, 2};
    for (int i = 0; i < 2; i++) begin
      do_start(ws[i], hs[i], 16'h0, 0);
      total++;
      if (done !== 1'b1 || out_valid !== 1'b0) begin
        bad++; $display("FAIL degen_%0d_done: got done=%b valid=%b, required 1 0", i, done, out_valid);
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        bad++; $display("FAIL degen_%0d_idle: got done=%b busy=%b valid=%b, required 0 0 0",
                        i, done, busy, out_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    bit got;
    out_ready = 1'b0;
    run_frame(30, 30, 16'h0, 0, 0, 0, 16, -1, -1);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b1 || fifo_afull !== 1'b1 || drop_flag !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL bp_full: got valid=%b afull=%b drop=%b busy=%b, required 1 1 1 1",
                      out_valid, fifo_afull, drop_flag, busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if ({out_last, out_data} !== exp_q[0]) begin
        bad++; $display("FAIL bp_hold: got %h, required %h", {out_last, out_data}, exp_q[0]);
      end
    end
    for (int p = 0; p < 16; p++) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (fifo_afull !== ((15 - p) >= 12)) begin
        bad++; $display("FAIL bp_afull_%0d: got %b, required %b", 15 - p, fifo_afull, ((15 - p) >= 12));
      end
    end
    total++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++; $display("FAIL bp_drained: got valid=%b pending=%0d, required 0 0", out_valid, exp_q.size());
    end
    out_ready = 1'b1;
    wait_done(50, got);
    total++;
    if (got !== 1'b1 || drop_flag !== 1'b1) begin
      bad++; $display("FAIL bp_done: got done=%b drop=%b, required 1 1", got, drop_flag);
    end
  endtask

  task automatic test_reset_mid;
    bit got;
    run_frame(5, 5, 16'h0010, 0, 2, 0, 1000, 7, -1);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    total++;
    if ({out_valid, busy, done, sat_flag, drop_flag} !== 5'b0) begin
      bad++; $display("FAIL midrst_state: got v/b/d/s/dr=%b, required 00000",
                      {out_valid, busy, done, sat_flag, drop_flag});
    end
    rst = 1'b1;
    run_frame(7, 6, 16'hFF80, 1, 2, 0, 1000, -1, -1);
    wait_done(200, got);
    total++;
    if (got !== 1'b1 || exp_q.size() != 0) begin
      bad++; $display("FAIL post_rst_frame: got done=%b pending=%0d, required 1 0", got, exp_q.size());
    end
    total++;
    if (sat_flag !== exp_sat || drop_flag !== 1'b0) begin
      bad++; $display("FAIL post_rst_flags: got sat=%b drop=%b, required %b 0", sat_flag, drop_flag, exp_sat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_arith();
    test_control();
    test_degenerate();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
